// File: rtl/mux_8to1_a.sv
// Registered 8-to-1 lane selector built as one-hot decode, per-lane AND mask and OR reduction.
// F_comb is the same-cycle pick; F is its registered copy with load enable and async clear.
module mux_8to1_a #(
  parameter int LANE_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [8*LANE_W-1:0]   A,
  input  logic [2:0]            Sel,
  output logic [LANE_W-1:0]     F_comb,
  output logic [LANE_W-1:0]     F
);

  logic [7:0]        sel_dec;
  logic [LANE_W-1:0] lane_masked [8];
  logic [LANE_W-1:0] f_d;
  logic [LANE_W-1:0] f_q;

  // Each decode output is the AND of the three select literals, so exactly one lane is enabled.
  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign sel_dec[i]     = (i[0] ? Sel[0] : ~Sel[0]) &
                            (i[1] ? Sel[1] : ~Sel[1]) &
                            (i[2] ? Sel[2] : ~Sel[2]);
    assign lane_masked[i] = A[i*LANE_W +: LANE_W] & {LANE_W{sel_dec[i]}};
  end

  always_comb begin
    // NOTE: the accumulator is given a value before the loop so every path assigns it and no latch is inferred.
    F_comb = '0;
    for (int i = 0; i < 8; i++) begin
      F_comb = F_comb | lane_masked[i];
    end
  end

  always_comb begin
    f_d = en ? F_comb : f_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      f_q <= '0;
    end else begin
      f_q <= f_d;
    end
  end

  assign F = f_q;

endmodule

// File: tb/tb_mux_8to1_a.sv
// Self-checking bench for mux_8to1_a: reset, directed tables, walking one, wide lanes and random traffic
// against a shift-and-mask reference model, on a 1-bit-lane and a 4-bit-lane instance.
module tb_mux_8to1_a;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  a1;
  logic [31:0] a4;
  logic [2:0]  sel;
  logic [0:0]  f1_comb, f1;
  logic [3:0]  f4_comb, f4;

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] m_f1, m_f4;

  mux_8to1_a #(.LANE_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a1), .Sel(sel), .F_comb(f1_comb), .F(f1)
  );

  mux_8to1_a #(.LANE_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .A(a4), .Sel(sel), .F_comb(f4_comb), .F(f4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] a;
    logic [2:0] sel;
    logic       en;
    logic       exp_comb;
    logic       exp_f;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: lane k is bits [k*w +: w], extracted by shift and mask.
  function automatic logic [3:0] lane(input logic [31:0] a, input int s, input int w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return 4'((a >> (s * w)) & mask);
  endfunction

  // Called just after a falling edge; checks comb outputs, crosses one rising edge, checks F.
  task automatic apply(input logic [7:0] va1, input logic [31:0] va4,
                       input logic [2:0] vs, input logic ve);
    a1 = va1; a4 = va4; sel = vs; en = ve;
    #1;
    check("comb1", 32'(f1_comb), 32'(lane(32'(va1), int'(vs), 1)));
    check("comb4", 32'(f4_comb), 32'(lane(va4, int'(vs), 4)));
    @(posedge clk);
    if (ve) begin
      m_f1 = lane(32'(va1), int'(vs), 1);
      m_f4 = lane(va4, int'(vs), 4);
    end
    #1;
    check("f1", 32'(f1), 32'(m_f1));
    check("f4", 32'(f4), 32'(m_f4));
    @(negedge clk);
  endtask

  initial begin
    // Hold sequence, then simultaneous Sel/A change 3->6 with 08->40.
    vecs[0] = '{a: 8'h04, sel: 3'd2, en: 1'b1, exp_comb: 1'b1, exp_f: 1'b1};
    vecs[1] = '{a: 8'h00, sel: 3'd2, en: 1'b0, exp_comb: 1'b0, exp_f: 1'b1};
    vecs[2] = '{a: 8'h00, sel: 3'd2, en: 1'b0, exp_comb: 1'b0, exp_f: 1'b1};
    vecs[3] = '{a: 8'h00, sel: 3'd2, en: 1'b0, exp_comb: 1'b0, exp_f: 1'b1};
    vecs[4] = '{a: 8'h00, sel: 3'd2, en: 1'b1, exp_comb: 1'b0, exp_f: 1'b0};
    vecs[5] = '{a: 8'h08, sel: 3'd3, en: 1'b1, exp_comb: 1'b1, exp_f: 1'b1};
    vecs[6] = '{a: 8'h40, sel: 3'd6, en: 1'b1, exp_comb: 1'b1, exp_f: 1'b1};

    // Reset held across several edges with a selected lane of ones and en high.
    rst_n = 1'b0; a1 = 8'hFF; a4 = 32'hFFFF_FFFF; sel = 3'd5; en = 1'b1;
    #1;
    check("rst_f1_async", 32'(f1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_f1", 32'(f1), 32'd0);
      check("rst_f4", 32'(f4), 32'd0);
      check("rst_comb1", 32'(f1_comb), 32'd1);
      check("rst_comb4", 32'(f4_comb), 32'hF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_f1 = '0; m_f4 = '0;

    // Walking one plus all-zero pattern for every select code.
    for (int s = 0; s < 8; s++) begin
      for (int p = 0; p <= 8; p++) begin
        logic [7:0] pat;
        pat = (p < 8) ? 8'(8'd1 << p) : 8'h00;
        apply(pat, 32'(pat) * 32'h11, 3'(s), 1'b1);
        check("walk_f1", 32'(f1), 32'((p == s) ? 1 : 0));
      end
    end

    // Table-driven hold and simultaneous-change vectors.
    for (int i = 0; i < 7; i++) begin
      a1 = vecs[i].a; sel = vecs[i].sel; en = vecs[i].en;
      #1;
      check("tbl_comb", 32'(f1_comb), 32'(vecs[i].exp_comb));
      apply(vecs[i].a, 32'h0, vecs[i].sel, vecs[i].en);
      check("tbl_f", 32'(f1), 32'(vecs[i].exp_f));
    end

    // Wide lanes: lane k holds the value k.
    for (int k = 0; k < 8; k++) begin
      apply(8'h00, 32'h7654_3210, 3'(k), 1'b1);
      check("wide_f4", 32'(f4), 32'(k));
    end

    // Async reset pulse between edges.
    apply(8'h80, 32'h9000_0000, 3'd7, 1'b1);
    check("arst_pre_f1", 32'(f1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_f1", 32'(f1), 32'd0);
    check("arst_f4", 32'(f4), 32'd0);
    check("arst_comb1", 32'(f1_comb), 32'd1);
    m_f1 = '0; m_f4 = '0;
    #1 rst_n = 1'b1;
    #1;
    check("arst_hold_f1", 32'(f1), 32'd0);
    @(negedge clk);
    apply(8'h80, 32'h9000_0000, 3'd7, 1'b1);
    check("arst_post_f1", 32'(f1), 32'd1);
    check("arst_post_f4", 32'(f4), 32'h9);

    // Random traffic with en low about a quarter of the time.
    for (int i = 0; i < 300; i++) begin
      apply(8'($urandom), $urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
